equiv_vector_checker: RTL and testbench

//  Synthesizable, parametrised stimulus/compare engine for equivalence fuzzing.
//  It drives one input vector into two DUT copies, such as the RTL model and the synthesized netlist.

---
 rtl/equiv_chk_pkg.sv | 35 +++
 rtl/vec_xorshift64.sv | 30 +++
 rtl/equiv_vector_checker.sv | 152 +++++++++++++++
 tb/tb_equiv_vector_checker.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/equiv_chk_pkg.sv
// Shared types and helpers for the equivalence vector checker: FSM states,
// generator constants, the MISR input fold and the xorshift64 step.
package equiv_chk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    APPLY,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [63:0] GOLDEN64     = 64'h9E3779B97F4A7C15;
  localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;
  localparam int          FOLD_MAX_W   = 1024;

  function automatic logic [63:0] xorshift64_step(input logic [63:0] x);
    logic [63:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  // XOR of w-bit chunks of v (1 <= w <= 64); zero-extended inputs pad the last chunk.
  function automatic logic [63:0] fold(input logic [FOLD_MAX_W-1:0] v, input int w);
    logic [63:0] acc;
    acc = '0;
    for (int i = 0; i < FOLD_MAX_W; i++) begin
      acc[i % w] = acc[i % w] ^ v[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/vec_xorshift64.sv
// One 64-bit xorshift64 chunk of the stimulus generator; next is the value the
// chunk would take on advance, so a load can capture it in the same cycle.
module vec_xorshift64
  import equiv_chk_pkg::*;
#(
  parameter logic [63:0] SEED = 64'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_seed,
  input  logic        advance,
  output logic [63:0] next
);

  // An all-zero state would lock the generator at zero forever.
  localparam logic [63:0] SEED_NZ = (SEED == 64'h0) ? 64'h1 : SEED;

  logic [63:0] x_q;

  always_ff @(posedge clk) begin
    if (rst || load_seed) begin
      x_q <= SEED_NZ;
    end else if (advance) begin
      x_q <= xorshift64_step(x_q);
    end
  end

  assign next = xorshift64_step(x_q);

endmodule

// File: rtl/equiv_vector_checker.sv
// Drives identical vectors into two DUT copies, compares their outputs after a
// fixed latency and folds each into a MISR signature; reports pass/fail per run.
module equiv_vector_checker
  import equiv_chk_pkg::*;
#(
  parameter int              IN_W    = 256,
  parameter int              OUT_W   = 336,
  parameter int              NUM_VEC = 20,
  parameter int              LATENCY = 1,
  parameter int              MISR_W  = 32,
  parameter logic [MISR_W-1:0] POLY  = MISR_W'(DEFAULT_POLY),
  parameter logic [63:0]     SEED    = 64'h1,
  parameter int              CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              vec_valid,
  output logic              vec_ready,
  input  logic [IN_W-1:0]   vec_data,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_a_y,
  input  logic [OUT_W-1:0]  dut_b_y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic [CNT_W-1:0]  first_fail_idx,
  output logic [MISR_W-1:0] sig_a,
  output logic [MISR_W-1:0] sig_b
);

  localparam int NCHUNK = (IN_W + 63) / 64;
  localparam int IDX_RAW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam int IDX_W = (IDX_RAW > CNT_W) ? IDX_RAW : CNT_W;
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
  localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(LATENCY - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t            st;
  logic              mode_r;
  logic [IDX_W-1:0]  idx;
  logic [LAT_W-1:0]  lat_cnt;

  logic              start_ok;
  logic              gen_adv;
  logic [NCHUNK*64-1:0] gen_next;

  logic              miss;
  logic [MISR_W-1:0] fold_a, fold_b, sig_a_next, sig_b_next;

  assign start_ok  = start && (st == IDLE || st == DONE);
  assign gen_adv   = (st == LOAD) && !mode_r;
  assign vec_ready = (st == LOAD) && mode_r;

  for (genvar k = 0; k < NCHUNK; k++) begin : g_chunk
    vec_xorshift64 #(
      .SEED(SEED + 64'(k) * GOLDEN64)
    ) u_chunk (
      .clk      (clk),
      .rst      (rst),
      .load_seed(start_ok),
      .advance  (gen_adv),
      .next     (gen_next[k*64 +: 64])
    );
  end

  assign miss   = |(dut_a_y ^ dut_b_y);
  assign fold_a = MISR_W'(fold(FOLD_MAX_W'(dut_a_y), MISR_W));
  assign fold_b = MISR_W'(fold(FOLD_MAX_W'(dut_b_y), MISR_W));
  assign sig_a_next = {sig_a[MISR_W-2:0], 1'b0} ^ (sig_a[MISR_W-1] ? POLY : '0) ^ fold_a;
  assign sig_b_next = {sig_b[MISR_W-2:0], 1'b0} ^ (sig_b[MISR_W-1] ? POLY : '0) ^ fold_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      st             <= IDLE;
      mode_r         <= 1'b0;
      idx            <= '0;
      lat_cnt        <= '0;
      dut_in         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_count <= '0;
      first_fail_idx <= '1;
      sig_a          <= '0;
      sig_b          <= '0;
    end else begin
      case (st)
        IDLE, DONE: begin
          if (start) begin
            mode_r         <= mode;
            idx            <= '0;
            mismatch_count <= '0;
            first_fail_idx <= '1;
            sig_a          <= '0;
            sig_b          <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            st             <= LOAD;
          end
        end
        LOAD: begin
          if (!mode_r) begin
            dut_in  <= IN_W'(gen_next);
            lat_cnt <= '0;
            st      <= APPLY;
          end else if (vec_valid) begin
            dut_in  <= vec_data;
            lat_cnt <= '0;
            st      <= APPLY;
          end
        end
        APPLY: begin
          if (lat_cnt == LAST_LAT) begin
            st <= SAMPLE;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          if (miss) begin
            mismatch_count <= sat_inc(mismatch_count);
            if (&first_fail_idx) begin
              first_fail_idx <= CNT_W'(idx);
            end
          end
          sig_a <= sig_a_next;
          sig_b <= sig_b_next;
          if (idx == LAST_IDX) begin
            busy <= 1'b0;
            done <= 1'b1;
            // Count after this sample is zero only if it was zero and this vector matched.
            pass <= !miss && (mismatch_count == '0) && (sig_a_next == sig_b_next);
            st   <= DONE;
          end else begin
            idx <= idx + 1'b1;
            st  <= LOAD;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_equiv_vector_checker.sv
// Bench for equiv_vector_checker: echo DUTs around the checker, an independent
// generator/MISR model, and a scoreboard of expected dut_in vectors.
module tb_equiv_vector_checker;

  localparam int IN_W  = 256;
  localparam int OUT_W = 336;
  localparam int NV    = 20;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, mode, vec_valid, vec_ready, busy, done, pass;
  logic [IN_W-1:0]   vec_data, dut_in, echo_q;
  logic [OUT_W-1:0]  a_y, b_y;
  logic [15:0]       mm, ffi;
  logic [31:0]       sig_a, sig_b;
  logic              flip_en;
  logic [IN_W-1:0]   flip_vec;

  logic              s_rst, s_start, s_mode, s_valid, s_ready, s_busy, s_done, s_pass;
  logic [IN_W-1:0]   s_data, s_dut_in, s_echo_q;
  logic [OUT_W-1:0]  s_a_y, s_b_y;
  logic [3:0]        s_mm, s_ffi;
  logic [31:0]       s_sig_a, s_sig_b;

  always @(posedge clk) echo_q <= dut_in;
  assign a_y = {echo_q[79:0], echo_q};
  assign b_y = a_y ^ {{(OUT_W-1){1'b0}}, flip_en && (echo_q == flip_vec)};

  always @(posedge clk) s_echo_q <= s_dut_in;
  assign s_a_y = {s_echo_q[79:0], s_echo_q};
  assign s_b_y = ~s_a_y;

  equiv_vector_checker dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
    .dut_in(dut_in), .dut_a_y(a_y), .dut_b_y(b_y),
    .busy(busy), .done(done), .pass(pass),
    .mismatch_count(mm), .first_fail_idx(ffi), .sig_a(sig_a), .sig_b(sig_b)
  );

  equiv_vector_checker #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(s_rst), .start(s_start), .mode(s_mode),
    .vec_valid(s_valid), .vec_ready(s_ready), .vec_data(s_data),
    .dut_in(s_dut_in), .dut_a_y(s_a_y), .dut_b_y(s_b_y),
    .busy(s_busy), .done(s_done), .pass(s_pass),
    .mismatch_count(s_mm), .first_fail_idx(s_ffi), .sig_a(s_sig_a), .sig_b(s_sig_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model
  function automatic logic [63:0] xs(input logic [63:0] x);
    logic [63:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 7);
    return t ^ (t << 17);
  endfunction

  function automatic logic [OUT_W-1:0] echo_y(input logic [IN_W-1:0] v);
    return {v[79:0], v};
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [OUT_W-1:0] y);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < OUT_W; i++) acc[i % 32] = acc[i % 32] ^ y[i];
    return {sig[30:0], 1'b0} ^ (sig[31] ? POLY : 32'h0) ^ acc;
  endfunction

  logic [IN_W-1:0] vecs [NV];
  logic [IN_W-1:0] list [NV];
  logic [31:0]     exp_sig, exp_sig_flip, exp_sig_list;

  task automatic build_model();
    logic [63:0] s [4];
    logic [31:0] sa, sb, sl;
    logic [OUT_W-1:0] y;
    for (int k = 0; k < 4; k++) begin
      s[k] = 64'h1 + 64'(k) * 64'h9E3779B97F4A7C15;
      if (s[k] == 64'h0) s[k] = 64'h1;
    end
    sa = '0; sb = '0; sl = '0;
    for (int v = 0; v < NV; v++) begin
      for (int k = 0; k < 4; k++) s[k] = xs(s[k]);
      vecs[v] = {s[3], s[2], s[1], s[0]};
      list[v] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      y  = echo_y(vecs[v]);
      sa = misr_step(sa, y);
      sb = misr_step(sb, (v == 7) ? (y ^ {{(OUT_W-1){1'b0}}, 1'b1}) : y);
      sl = misr_step(sl, echo_y(list[v]));
    end
    exp_sig = sa; exp_sig_flip = sb; exp_sig_list = sl;
  endtask

  // Scoreboard: expected dut_in values in drive order
  logic [IN_W-1:0] exp_q [$];
  logic [IN_W-1:0] prev_in;
  int              seen = 0;
  bit              mode_run = 1'b0;
  int              rdy_bad = 0;

  always @(negedge clk) begin
    if (busy === 1'b1 && dut_in !== prev_in) begin
      if (exp_q.size() == 0) check("sb_unexpected_vec", OUT_W'(exp_q.size()), OUT_W'(1));
      else check("dut_in", OUT_W'(dut_in), OUT_W'(exp_q.pop_front()));
      seen++;
    end
    if (vec_ready === 1'b1 && (!mode_run || busy !== 1'b1)) rdy_bad++;
    prev_in = dut_in;
  end

  task automatic check_reset();
    check("rst_dut_in", OUT_W'(dut_in), '0);
    check("rst_busy", OUT_W'(busy), '0);
    check("rst_done", OUT_W'(done), '0);
    check("rst_pass", OUT_W'(pass), '0);
    check("rst_ready", OUT_W'(vec_ready), '0);
    check("rst_mm", OUT_W'(mm), '0);
    check("rst_ffi", OUT_W'(ffi), OUT_W'(16'hFFFF));
    check("rst_sig_a", OUT_W'(sig_a), '0);
    check("rst_sig_b", OUT_W'(sig_b), '0);
  endtask

  task automatic pulse_start(input bit m);
    @(negedge clk); start = 1'b1; mode = m;
    @(negedge clk); start = 1'b0; mode = 1'b0;
    check("start_busy", OUT_W'(busy), OUT_W'(1));
    check("start_done", OUT_W'(done), '0);
    check("start_mm", OUT_W'(mm), '0);
    check("start_ffi", OUT_W'(ffi), OUT_W'(16'hFFFF));
    check("start_sig", OUT_W'(sig_a), '0);
  endtask

  task automatic run_internal(input bit flip, input bit poke, input logic [31:0] esb,
                              input logic [15:0] emm, input logic [15:0] effi, input bit epass);
    int cyc;
    mode_run = 1'b0;
    flip_en  = flip;
    for (int v = 0; v < NV; v++) exp_q.push_back(vecs[v]);
    pulse_start(1'b0);
    cyc = 0;
    while (done !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      start = poke && (cyc == 10 || cyc == 31 || cyc == 45);
      mode  = start;
    end
    start = 1'b0; mode = 1'b0;
    check("run_latency", OUT_W'(cyc), OUT_W'(60));
    check("run_busy_off", OUT_W'(busy), '0);
    check("run_pass", OUT_W'(pass), OUT_W'(epass));
    check("run_mm", OUT_W'(mm), OUT_W'(emm));
    check("run_ffi", OUT_W'(ffi), OUT_W'(effi));
    check("run_sig_a", OUT_W'(sig_a), OUT_W'(exp_sig));
    check("run_sig_b", OUT_W'(sig_b), OUT_W'(esb));
    check("run_sb_drained", OUT_W'(exp_q.size()), '0);
    flip_en = 1'b0;
  endtask

  task automatic run_external();
    int n;
    mode_run = 1'b1;
    pulse_start(1'b1);
    for (int i = 0; i < NV; i++) begin
      repeat ($urandom_range(0, 5)) begin
        vec_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
      end
      vec_valid = 1'b1;
      vec_data  = list[i];
      exp_q.push_back(list[i]);
      n = 0;
      while (vec_ready !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("ext_ready_seen", OUT_W'(vec_ready), OUT_W'(1));
      @(posedge clk);
      #1 vec_valid = 1'b0;
      vec_data = ~list[i];
      @(negedge clk);
      check("ext_ready_drop", OUT_W'(vec_ready), '0);
    end
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ext_done", OUT_W'(done), OUT_W'(1));
    check("ext_pass", OUT_W'(pass), OUT_W'(1));
    check("ext_mm", OUT_W'(mm), '0);
    check("ext_sig_a", OUT_W'(sig_a), OUT_W'(exp_sig_list));
    check("ext_sig_b", OUT_W'(sig_b), OUT_W'(exp_sig_list));
    check("ext_sb_drained", OUT_W'(exp_q.size()), '0);
    mode_run = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, target;
    rst = 1'b1; start = 1'b0; mode = 1'b0; vec_valid = 1'b0; vec_data = '0; flip_en = 1'b0;
    s_rst = 1'b1; s_start = 1'b0; s_mode = 1'b0; s_valid = 1'b0; s_data = '0;
    build_model();
    flip_vec = vecs[7];
    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0; s_rst = 1'b0;

    // Clean run with start pokes while busy, then a fault on vector 7, then replay from DONE
    run_internal(1'b0, 1'b1, exp_sig, 16'd0, 16'hFFFF, 1'b1);
    run_internal(1'b1, 1'b0, exp_sig_flip, 16'd1, 16'd7, 1'b0);
    check("flip_sig_differ", OUT_W'(sig_a != sig_b), OUT_W'(1));
    run_internal(1'b0, 1'b0, exp_sig, 16'd0, 16'hFFFF, 1'b1);

    run_external();

    // Reset in APPLY of vector 5, then an uninterrupted replay
    for (int v = 0; v < NV; v++) exp_q.push_back(vecs[v]);
    target = seen + 6;
    pulse_start(1'b0);
    n = 0;
    while (seen < target && n < 200) begin
      @(negedge clk);
      #1 n++;
    end
    check("mid_vec5_reached", OUT_W'(seen), OUT_W'(target));
    rst = 1'b1;
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    exp_q.delete();
    run_internal(1'b0, 1'b0, exp_sig, 16'd0, 16'hFFFF, 1'b1);

    // Narrow counters with every vector mismatching
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    n = 0;
    while (s_done !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("sat_done", OUT_W'(s_done), OUT_W'(1));
    check("sat_mm", OUT_W'(s_mm), OUT_W'(4'hF));
    check("sat_ffi", OUT_W'(s_ffi), '0);
    check("sat_pass", OUT_W'(s_pass), '0);

    check("ready_outside_load", OUT_W'(rdy_bad), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
